// File: rtl/dmem_responder.sv
// Data-memory responder: latches one DREQ, waits LATENCY cycles, then accesses a word array and pulses DACK.
// Optional misalignment checking with DERR is enabled by defining DMEM_ALIGN_CHK_EN.
module dmem_responder #(
  parameter int ADDR_W  = 12,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              DREQ,
  input  logic              DRW,
  input  logic [ADDR_W-1:0] DADDR,
  input  logic [31:0]       DWDATA,
  output logic [31:0]       DRDATA,
  output logic              DACK,
  output logic              DSTALL
`ifdef DMEM_ALIGN_CHK_EN
  ,
  output logic              DERR
`endif
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [3:0]         cnt_r, cnt_s;
  logic               accept_s;
  logic               rw_r;
  logic [IDX_W-1:0]   idx_r;
  logic [31:0]        wdata_r;
  logic [31:0]        drdata_r;
  logic               dack_r;
  logic               derr_r;
  logic               complete_s;
  logic               acc_rw_s;
  logic [IDX_W-1:0]   acc_idx_s;
  logic [31:0]        acc_wdata_s;
  logic               acc_mis_s;
  logic               in_range_s;
  logic               access_ok_s;
  logic [MEM_AW-1:0]  mem_idx_s;
  logic [31:0]        mem [DEPTH];

  // Next-state and request acceptance
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (DREQ) begin
          accept_s = 1'b1;
          cnt_s    = CNT_INIT;
          state_s  = (LATENCY == 1) ? ST_DONE : ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r <= 4'd1) begin
          cnt_s   = 4'd0;
          state_s = ST_DONE;
        end else begin
          cnt_s   = cnt_r - 4'd1;
          state_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        cnt_s   = 4'd0;
        state_s = ST_IDLE;
      end
      default: begin
        cnt_s   = 4'd0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // Access fields: live inputs when a 1-cycle access completes straight from IDLE, else the latched copy
  always_comb begin
    complete_s = RSTN && (state_s == ST_DONE) && (state_r != ST_DONE);
    if (state_r == ST_IDLE) begin
      acc_rw_s    = DRW;
      acc_idx_s   = DADDR[ADDR_W-1:2];
      acc_wdata_s = DWDATA;
    end else begin
      acc_rw_s    = rw_r;
      acc_idx_s   = idx_r;
      acc_wdata_s = wdata_r;
    end
    in_range_s  = (32'(acc_idx_s) < 32'(DEPTH));
    mem_idx_s   = MEM_AW'(acc_idx_s);
    access_ok_s = complete_s && !acc_mis_s;
  end

`ifdef DMEM_ALIGN_CHK_EN
  logic mis_r;

  // Misalignment of the request being completed
  always_comb begin
    if (state_r == ST_IDLE) begin
      acc_mis_s = |DADDR[1:0];
    end else begin
      acc_mis_s = mis_r;
    end
  end

  // Latched misalignment flag
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      mis_r <= 1'b0;
    end else if (accept_s) begin
      mis_r <= |DADDR[1:0];
    end
  end

  assign DERR = derr_r;
`else
  logic unused_addr_lsb_s;
  assign unused_addr_lsb_s = ^DADDR[1:0];
  assign acc_mis_s = 1'b0;
`endif

  // FSM state, latency counter and latched request fields
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      rw_r    <= 1'b0;
      idx_r   <= '0;
      wdata_r <= 32'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        rw_r    <= DRW;
        idx_r   <= DADDR[ADDR_W-1:2];
        wdata_r <= DWDATA;
      end
    end
  end

  // Registered completion outputs; DRDATA only moves on a completing aligned load
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      drdata_r <= 32'd0;
      dack_r   <= 1'b0;
      derr_r   <= 1'b0;
    end else begin
      dack_r <= complete_s;
      derr_r <= complete_s && acc_mis_s;
      if (access_ok_s && !acc_rw_s) begin
        drdata_r <= in_range_s ? mem[mem_idx_s] : 32'd0;
      end
    end
  end

  // Word array, deliberately not reset; out-of-range stores are dropped
  always_ff @(posedge CLK) begin
    if (access_ok_s && acc_rw_s && in_range_s) begin
      mem[mem_idx_s] <= acc_wdata_s;
    end
  end

  assign DRDATA = drdata_r;
  assign DACK   = dack_r;
  assign DSTALL = RSTN && (((state_r == ST_IDLE) && DREQ) || (state_r == ST_WAIT));

endmodule
